// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter that merges N_PORTS AXI-stream inputs onto one output.
// The grant locks for the whole packet; the data path is purely combinational.
module axis_rr_arbiter #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_PORTS*DATA_W-1:0]   s_data,
  input  logic [N_PORTS-1:0]          s_valid,
  input  logic [N_PORTS-1:0]          s_last,
  output logic [N_PORTS-1:0]          s_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic [$clog2(N_PORTS)-1:0]  grant_id,
  output logic                        busy,
  output logic [CNT_W-1:0]            pkt_count
);

  localparam int unsigned GW = $clog2(N_PORTS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PASS = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_valid;
  logic [GW-1:0]    pick;

  // First requester after last_ptr, wrapping; the port that just finished is searched last.
  always_comb begin
    int unsigned idx;
    logic [GW-1:0] cand;
    pick_valid = 1'b0;
    pick       = '0;
    idx        = 0;
    cand       = '0;
    for (int unsigned i = 1; i <= N_PORTS; i++) begin
      idx  = (32'(last_ptr_q) + i) % N_PORTS;
      cand = GW'(idx);
      if (!pick_valid && s_valid[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    m_data  = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    s_ready = '0;
    if (state_q == PASS) begin
      m_data           = s_data[32'(grant_q)*DATA_W +: DATA_W];
      m_valid          = s_valid[grant_q];
      m_last           = s_last[grant_q];
      s_ready[grant_q] = m_ready;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = PASS;
        end
      end
      PASS: begin
        if (m_valid && m_ready && m_last) begin
          state_d    = IDLE;
          last_ptr_d = grant_q;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_ptr_q <= GW'(N_PORTS - 1);
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == PASS);
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: queued per-port sources, expected-beat queue, negedge monitor.
module tb_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_valid, s_last, s_ready, w_s_ready;
  logic [DW-1:0]   m_data, w_m_data;
  logic            m_valid, m_last, m_ready, w_m_valid, w_m_last;
  logic [1:0]      grant_id, w_grant_id;
  logic            busy, w_busy;
  logic [15:0]     pkt_count;
  logic [3:0]      w_pkt_count;

  axis_rr_arbiter #(.N_PORTS(N), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count));

  axis_rr_arbiter #(.N_PORTS(N), .DATA_W(DW), .CNT_W(4)) u_wrap (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(w_s_ready), .m_data(w_m_data), .m_valid(w_m_valid), .m_last(w_m_last),
    .m_ready(m_ready), .grant_id(w_grant_id), .busy(w_busy), .pkt_count(w_pkt_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0] port;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       expq[$];
  int         hs_cyc[$];
  logic [8:0] srcq[N][$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic src_push(input int p, input logic [7:0] d, input logic l);
    srcq[p].push_back({l, d});
  endtask

  task automatic exp_push(input int p, input logic [7:0] d, input logic l);
    exp_t e;
    e.port = 2'(p);
    e.data = d;
    e.last = l;
    expq.push_back(e);
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((expq.size() != 0 || busy) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check("drain_done", {31'd0, (expq.size() == 0 && !busy)}, 32'd1);
  endtask

  // Source model: snapshot handshakes at negedge, advance the per-port queues after posedge.
  initial begin
    logic [N-1:0] hs;
    logic [8:0]   e;
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    forever begin
      @(negedge clk);
      hs = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          e = srcq[i][0];
          s_valid[i]          = 1'b1;
          s_data[i*DW +: DW]  = e[7:0];
          s_last[i]           = e[8];
        end else begin
          s_valid[i]          = 1'b0;
          s_data[i*DW +: DW]  = '0;
          s_last[i]           = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && m_valid && m_ready) begin
      hs_cyc.push_back(cyc);
      n_cmp++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL beat: got unexpected beat port %0d data 0x%0h last %0b, expected none",
                 grant_id, m_data, m_last);
      end else begin
        e = expq.pop_front();
        if ({grant_id, m_data, m_last} !== {e.port, e.data, e.last}) begin
          n_err++;
          $display("FAIL beat: got port %0d data 0x%0h last %0b, expected port %0d data 0x%0h last %0b",
                   grant_id, m_data, m_last, e.port, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    m_ready = 1'b1;

    // Reset, then ten idle cycles
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_m_valid", {31'd0, m_valid}, 32'd0);
    end
    check("idle_s_ready", {28'd0, s_ready}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_pkt_count", {16'd0, pkt_count}, 32'd0);
    check("idle_grant_id", {30'd0, grant_id}, 32'd0);
    check("idle_m_data", {24'd0, m_data}, 32'd0);

    // All four ports, one 3-beat packet each
    hs_cyc.delete();
    for (int p = 0; p < N; p++)
      for (int b = 0; b < 3; b++) begin
        src_push(p, 8'(8'h10 * p + b), b == 2);
        exp_push(p, 8'(8'h10 * p + b), b == 2);
      end
    drain(100);
    check("rr_beats", hs_cyc.size(), 12);
    if (hs_cyc.size() == 12)
      for (int j = 1; j < 12; j++)
        check("rr_gap", hs_cyc[j] - hs_cyc[j-1], (j % 3 == 0) ? 2 : 1);
    check("rr_pkt_count", {16'd0, pkt_count}, 32'd4);

    // Port 2 alone, two single-beat packets
    hs_cyc.delete();
    src_push(2, 8'hA5, 1'b1); exp_push(2, 8'hA5, 1'b1);
    src_push(2, 8'h5A, 1'b1); exp_push(2, 8'h5A, 1'b1);
    drain(50);
    check("single_beats", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2) check("single_gap", hs_cyc[1] - hs_cyc[0], 2);
    check("single_pkt_count", {16'd0, pkt_count}, 32'd6);

    // Port 1 stalled mid-packet while port 3 requests
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      src_push(1, 8'(8'h10 + b), b == 2);
      exp_push(1, 8'(8'h10 + b), b == 2);
    end
    k = 0;
    while (!busy && k < 20) begin @(negedge clk); k++; end
    check("stall_granted", {31'd0, busy}, 32'd1);
    check("stall_grant_id", {30'd0, grant_id}, 32'd1);
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    src_push(3, 8'h30, 1'b1);
    exp_push(3, 8'h30, 1'b1);
    @(negedge clk);
    check("stall_m_data", {24'd0, m_data}, 32'h11);
    check("stall_m_valid", {31'd0, m_valid}, 32'd1);
    check("stall_s_ready", {28'd0, s_ready}, 32'd0);
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    check("stall_m_data2", {24'd0, m_data}, 32'h11);
    check("stall_s_ready3", {31'd0, s_ready[3]}, 32'd0);
    check("stall_grant_hold", {30'd0, grant_id}, 32'd1);
    @(posedge clk); #1 m_ready = 1'b1;
    drain(50);
    check("stall_pkt_count", {16'd0, pkt_count}, 32'd8);

    // Reset while beat 2 of a 4-beat packet is on the output
    for (int b = 0; b < 4; b++) src_push(2, 8'(8'h20 + b), b == 3);
    exp_push(2, 8'h20, 1'b0);
    k = 0;
    while (!(m_valid && m_data == 8'h20) && k < 20) begin @(negedge clk); k++; end
    check("rst_first_beat", {24'd0, m_data}, 32'h20);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_s_ready", {28'd0, s_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    src_push(0, 8'h0F, 1'b1);
    exp_push(0, 8'h0F, 1'b1);
    for (int b = 1; b < 4; b++) exp_push(2, 8'(8'h20 + b), b == 3);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drain(50);
    check("rst_after_pkt_count", {16'd0, pkt_count}, 32'd2);

    // Counter wrap on the CNT_W=4 instance
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int j = 0; j < 17; j++) begin
      src_push(1, 8'(j), 1'b1);
      exp_push(1, 8'(j), 1'b1);
    end
    drain(120);
    check("wrap_pkt_count4", {28'd0, w_pkt_count}, 32'd1);
    check("wrap_pkt_count16", {16'd0, pkt_count}, 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
